// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S transmit path.
package i2s_pkg;

    localparam int BCLK_DIV   = 16;
    localparam int SMPL_W     = 16;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int DIV_CW     = $clog2(BCLK_DIV);
    localparam int BIT_CW     = $clog2(FRAME_BITS);
    localparam int SMPL_IW    = $clog2(SMPL_W);

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_tx_serializer_clk_gen.sv
// BCLK/LRCLK timing: clock divider, bit counter, frame and bit strobes.
module i2s_clk_gen #(
    parameter int BCLK_DIV = i2s_pkg::BCLK_DIV,
    parameter int SLOT_W   = i2s_pkg::SLOT_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    output logic                                    o_bclk,
    output logic                                    o_lrclk,
    output logic                                    o_frame_start,
    output logic                                    o_bit_adv,
    output logic [i2s_pkg::cnt_w(2*SLOT_W)-1:0]     o_bit_cnt
);
    import i2s_pkg::*;

    localparam int DW = cnt_w(BCLK_DIV);
    localparam int BW = cnt_w(2 * SLOT_W);

    logic [DW-1:0] r_div;
    logic [BW-1:0] r_bit;
    logic          r_bclk;
    logic          r_lrclk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_bclk  <= 1'b0;
            r_lrclk <= 1'b0;
        end else begin
            if (r_div == DW'(BCLK_DIV - 1)) begin
                r_div <= '0;
                r_bit <= (r_bit == BW'(2 * SLOT_W - 1)) ? '0 : r_bit + BW'(1);
            end else begin
                r_div <= r_div + DW'(1);
            end
            r_bclk  <= (r_div >= DW'(BCLK_DIV / 2));
            r_lrclk <= (r_bit >= BW'(SLOT_W));
        end
    end

    assign o_bclk        = r_bclk;
    assign o_lrclk       = r_lrclk;
    assign o_bit_adv     = (r_div == '0);
    assign o_frame_start = (r_div == '0) && (r_bit == '0);
    assign o_bit_cnt     = r_bit;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo pair to I2S serializer with one-pair holding buffer.
// Build option: I2S_TX_UNDERRUN_MUTE_EN sends zeros on underrun instead of repeating.
module i2s_tx_serializer #(
    parameter int BCLK_DIV = i2s_pkg::BCLK_DIV,
    parameter int SMPL_W   = i2s_pkg::SMPL_W,
    parameter int SLOT_W   = i2s_pkg::SLOT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SMPL_W-1:0] lft_in,
    input  logic [SMPL_W-1:0] rght_in,
    input  logic              vld_in,
    output logic              BCLK,
    output logic              LRCLK,
    output logic              SDATA,
    output logic              smpl_taken,
    output logic              underrun,
    output logic              overrun
);
    import i2s_pkg::*;

    localparam int BW = cnt_w(2 * SLOT_W);
    localparam int IW = cnt_w(SMPL_W);

    logic              w_frame_start;
    logic              w_bit_adv;
    logic [BW-1:0]     w_bit;
    logic              w_sd;
    logic [IW-1:0]     w_il;
    logic [IW-1:0]     w_ir;

    logic [SMPL_W-1:0] r_hold_l;
    logic [SMPL_W-1:0] r_hold_r;
    logic              r_full;
    logic [SMPL_W-1:0] r_sh_l;
    logic [SMPL_W-1:0] r_sh_r;
    logic              r_sdata;
    logic              r_taken;
    logic              r_under;
    logic              r_over;

    i2s_clk_gen #(
        .BCLK_DIV (BCLK_DIV),
        .SLOT_W   (SLOT_W)
    ) u_clk_gen (
        .clk           (clk),
        .rst           (rst),
        .o_bclk        (BCLK),
        .o_lrclk       (LRCLK),
        .o_frame_start (w_frame_start),
        .o_bit_adv     (w_bit_adv),
        .o_bit_cnt     (w_bit)
    );

    // One-bit I2S delay: MSB goes out one BCLK after the slot boundary.
    always_comb begin
        w_sd = 1'b0;
        w_il = IW'(SMPL_W - int'(w_bit));
        w_ir = IW'(SLOT_W + SMPL_W - int'(w_bit));
        if (w_bit >= BW'(1) && w_bit <= BW'(SMPL_W)) begin
            w_sd = r_sh_l[w_il];
        end else if (w_bit >= BW'(SLOT_W + 1) &&
                     w_bit <= BW'(SLOT_W + SMPL_W)) begin
            w_sd = r_sh_r[w_ir];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_full   <= 1'b0;
            r_sh_l   <= '0;
            r_sh_r   <= '0;
            r_sdata  <= 1'b0;
            r_taken  <= 1'b0;
            r_under  <= 1'b0;
            r_over   <= 1'b0;
        end else begin
            r_taken <= w_frame_start && r_full;
            r_under <= w_frame_start && !r_full;
            r_over  <= vld_in && r_full && !w_frame_start;
            if (vld_in) begin
                r_hold_l <= lft_in;
                r_hold_r <= rght_in;
                r_full   <= 1'b1;
            end else if (w_frame_start) begin
                r_full <= 1'b0;
            end
            if (w_frame_start) begin
                if (r_full) begin
                    r_sh_l <= r_hold_l;
                    r_sh_r <= r_hold_r;
                end else begin
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                    r_sh_l <= '0;
                    r_sh_r <= '0;
`else
                    r_sh_l <= r_sh_l;
                    r_sh_r <= r_sh_r;
`endif
                end
            end
            if (w_bit_adv) begin
                r_sdata <= w_sd;
            end
        end
    end

    assign SDATA      = r_sdata;
    assign smpl_taken = r_taken;
    assign underrun   = r_under;
    assign overrun    = r_over;

endmodule
